// File: rtl/fakong_pkg.sv
// Shared constants for the fakong command-frame path: SOF bytes, frame byte
// positions, status bit positions and the framer FSM encoding.
package fakong_pkg;

  localparam logic [7:0] SOF_L_DEF = 8'hEB;
  localparam logic [7:0] SOF_H_DEF = 8'h90;

  localparam int unsigned BYTE_SOF_L = 0;
  localparam int unsigned BYTE_SOF_H = 1;
  localparam int unsigned BYTE_SEQ   = 2;
  localparam int unsigned BYTE_STAT  = 3;
  localparam int unsigned BYTE_PAY0  = 4;
  localparam int unsigned BYTE_CS    = 31;

  localparam int unsigned PAY_BITS   = 216;

  localparam int unsigned STAT_LINK_OK  = 0;
  localparam int unsigned STAT_CS_ERR   = 1;
  localparam int unsigned STAT_NO_RESP  = 2;
  localparam int unsigned STAT_GOOD_LSB = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LATCH     = 3'd1;
  localparam logic [2:0] ST_SUM       = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  // Assemble the per-frame link status byte from the receive-side stickies.
  function automatic logic [7:0] status_byte(input logic [3:0] good_cnt,
                                             input logic cs_err,
                                             input logic no_resp);
    logic [7:0] s;
    s = '0;
    s[STAT_LINK_OK]               = (good_cnt != 4'd0) && !no_resp;
    s[STAT_CS_ERR]                = cs_err;
    s[STAT_NO_RESP]               = no_resp;
    s[STAT_GOOD_LSB +: 4]         = good_cnt;
    return s;
  endfunction

endpackage

// File: rtl/fakong_period_timer.sv
// Free-running frame period counter; tick marks the last count of each period.
module fakong_period_timer
  import fakong_pkg::*;
#(
  parameter logic [31:0] T_PERIOD = 32'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [31:0] count;

  assign tick = (count == T_PERIOD - 32'd1);

  // Count 0..T_PERIOD-1 and wrap, independent of any framing enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fakong_tx_framer.sv
// Periodic 32-byte command-frame builder for the fakong UART link. Builds
// SOF/seq/status/payload, sums a checksum one byte per cycle, then hands the
// frame to the transmitter via tx_frame_start / tx_busy.
module fakong_tx_framer
  import fakong_pkg::*;
#(
  parameter logic [31:0] T_PERIOD  = 32'd1_000_000,
  parameter logic [7:0]  T_SOF_L   = SOF_L_DEF,
  parameter logic [7:0]  T_SOF_H   = SOF_H_DEF,
  parameter logic [7:0]  BUSY_WAIT = 8'd8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [215:0] payload_in,
  input  logic         payload_valid,
  input  logic         rx_frame_done,
  input  logic         check_sum_error,
  input  logic         comNoResponse,
  input  logic         tx_busy,
  output logic [255:0] tx_frame,
  output logic         tx_frame_start,
  output logic [7:0]   seq,
  output logic         overrun,
  output logic         tx_err
);

  logic                tick;
  logic [PAY_BITS-1:0] shadow;
  logic [3:0]          good_cnt;
  logic                cs_sticky;
  logic                nr_sticky;
  logic [2:0]          state;
  logic [4:0]          idx;
  logic [7:0]          acc;
  logic [7:0]          seq_next;
  logic [7:0]          wait_cnt;
  logic [7:0]          cur_byte;
  logic [7:0]          acc_sum;

  fakong_period_timer #(
    .T_PERIOD(T_PERIOD)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cur_byte = tx_frame[{idx, 3'b000} +: 8];
  assign acc_sum  = acc + cur_byte;

  // Shadow payload register; LATCH reads the pre-update value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (payload_valid) begin
      shadow <= payload_in;
    end
  end

  // Receive-side stickies; events in the LATCH cycle seed the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt  <= '0;
      cs_sticky <= 1'b0;
      nr_sticky <= 1'b0;
    end else if (state == ST_LATCH) begin
      good_cnt  <= {3'b000, rx_frame_done};
      cs_sticky <= check_sum_error;
      nr_sticky <= comNoResponse;
    end else begin
      if (rx_frame_done && (good_cnt != 4'hF)) begin
        good_cnt <= good_cnt + 4'd1;
      end
      if (check_sum_error) begin
        cs_sticky <= 1'b1;
      end
      if (comNoResponse) begin
        nr_sticky <= 1'b1;
      end
    end
  end

  // Flag period ticks that cannot start a frame because one is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= tick && ((state != ST_IDLE) || (enable && tx_busy));
    end
  end

  // Framing FSM. Start pulse, checksum byte and seq are registered on the
  // SUM->START edge so they are all visible during the START cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      acc            <= '0;
      tx_frame       <= '0;
      tx_frame_start <= 1'b0;
      seq            <= '0;
      seq_next       <= '0;
      wait_cnt       <= '0;
      tx_err         <= 1'b0;
    end else begin
      tx_frame_start <= 1'b0;
      tx_err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && enable && !tx_busy) begin
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          tx_frame[8*BYTE_SOF_L +: 8]     <= T_SOF_L;
          tx_frame[8*BYTE_SOF_H +: 8]     <= T_SOF_H;
          tx_frame[8*BYTE_SEQ +: 8]       <= seq_next;
          tx_frame[8*BYTE_STAT +: 8]      <= status_byte(good_cnt, cs_sticky, nr_sticky);
          tx_frame[8*BYTE_PAY0 +: PAY_BITS] <= shadow;
          tx_frame[8*BYTE_CS +: 8]        <= 8'h00;
          acc   <= '0;
          idx   <= '0;
          state <= ST_SUM;
        end
        ST_SUM: begin
          acc <= acc_sum;
          idx <= idx + 5'd1;
          if (idx == 5'(BYTE_CS - 1)) begin
            tx_frame[8*BYTE_CS +: 8] <= acc_sum;
            tx_frame_start           <= 1'b1;
            seq                      <= seq_next;
            seq_next                 <= seq_next + 8'd1;
            state                    <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt <= 8'd1;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt >= BUSY_WAIT - 8'd1) begin
            // A lost frame burns one extra number so the ground side sees a gap.
            tx_err   <= 1'b1;
            seq_next <= seq_next + 8'd1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fakong_tx_framer.sv
// Self-checking bench for fakong_tx_framer with T_PERIOD=100. Expected frames
// come from an event log (cycle-stamped receive pulses and payload loads)
// summarised per latch window.
module tb_fakong_tx_framer;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [215:0] payload_in;
  logic         payload_valid;
  logic         rx_frame_done;
  logic         check_sum_error;
  logic         comNoResponse;
  logic         tx_busy;
  logic [255:0] tx_frame;
  logic         tx_frame_start;
  logic [7:0]   seq;
  logic         overrun;
  logic         tx_err;

  always #5 clk = ~clk;

  fakong_tx_framer #(
    .T_PERIOD (32'd100),
    .BUSY_WAIT(8'd8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .payload_in     (payload_in),
    .payload_valid  (payload_valid),
    .rx_frame_done  (rx_frame_done),
    .check_sum_error(check_sum_error),
    .comNoResponse  (comNoResponse),
    .tx_busy        (tx_busy),
    .tx_frame       (tx_frame),
    .tx_frame_start (tx_frame_start),
    .seq            (seq),
    .overrun        (overrun),
    .tx_err         (tx_err)
  );

  // Cycle number since reset release (matches the period counter value mod 100).
  int cyc = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_start = 0;
  int n_ovr   = 0;
  int n_err   = 0;
  always @(negedge clk) begin
    if (tx_frame_start === 1'b1) n_start <= n_start + 1;
    if (overrun === 1'b1)        n_ovr   <= n_ovr + 1;
    if (tx_err === 1'b1)         n_err   <= n_err + 1;
  end

  typedef struct {
    int           c;
    int           kind;   // 0 good frame, 1 checksum error, 2 no response, 3 payload load
    logic [215:0] pay;
  } ev_t;
  ev_t evq[$];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         lat_prev = 0;
  logic [7:0] m_seq    = 8'd0;
  int         exp_start = 0;
  int         exp_ovr   = 0;
  int         exp_err   = 0;
  logic [255:0] fr;
  logic [7:0]   s_fail;
  logic [7:0]   tmp8;
  logic [215:0] p;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [215:0] rand_pay();
    logic [215:0] r;
    for (int k = 0; k < 27; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  // Frame the transmitter should see for a latch at cycle hi, with the
  // status window opened at the previous latch lo.
  function automatic logic [255:0] model_frame(input int lo, input int hi, input logic [7:0] s);
    int           good;
    bit           cs;
    bit           nr;
    logic [215:0] pay;
    logic [7:0]   b [32];
    logic [7:0]   sum;
    logic [255:0] f;
    good = 0; cs = 0; nr = 0; pay = '0;
    foreach (evq[i]) begin
      if (evq[i].kind == 3) begin
        if (evq[i].c < hi) pay = evq[i].pay;
      end else if (evq[i].c >= lo && evq[i].c < hi) begin
        if (evq[i].kind == 0) good++;
        if (evq[i].kind == 1) cs = 1;
        if (evq[i].kind == 2) nr = 1;
      end
    end
    b[0] = 8'hEB;
    b[1] = 8'h90;
    b[2] = s;
    b[3] = {(good > 15 ? 4'd15 : 4'(good)), 1'b0, nr, cs, (good > 0 && !nr)};
    for (int k = 0; k < 27; k++) b[4 + k] = pay[8*k +: 8];
    sum = 8'd0;
    for (int k = 0; k < 31; k++) sum = sum + b[k];
    b[31] = sum;
    for (int k = 0; k < 32; k++) f[8*k +: 8] = b[k];
    return f;
  endfunction

  task automatic drive(input int c, input bit rfd, input bit cse, input bit cnr,
                       input bit pv, input logic [215:0] pay);
    wait_until(c);
    rx_frame_done   = rfd;
    check_sum_error = cse;
    comNoResponse   = cnr;
    payload_valid   = pv;
    payload_in      = pay;
    if (rfd) evq.push_back('{cyc, 0, '0});
    if (cse) evq.push_back('{cyc, 1, '0});
    if (cnr) evq.push_back('{cyc, 2, '0});
    if (pv)  evq.push_back('{cyc, 3, pay});
    @(negedge clk);
    rx_frame_done   = 1'b0;
    check_sum_error = 1'b0;
    comNoResponse   = 1'b0;
    payload_valid   = 1'b0;
  endtask

  task automatic rand_events(input int to, input bit allow_load);
    int c;
    c = cyc + int'($urandom_range(1, 5));
    while (c <= to) begin
      drive(c, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), allow_load && ($urandom_range(0, 3) == 0), rand_pay());
      c = c + int'($urandom_range(1, 5));
    end
  endtask

  // Expect a frame for tick tk; d<0 means the transmitter never answers.
  task automatic do_frame(input int tk, input int d, input int len);
    int s;
    int l;
    logic [255:0] exp;
    l = tk + 1;
    s = tk + 33;
    wait_until(s - 1);
    chk("start_early", tx_frame_start, 0);
    wait_until(s);
    exp = model_frame(lat_prev, l, m_seq);
    chk("start_pulse", tx_frame_start, 1);
    chk("frame", tx_frame, exp);
    chk("seq_out", seq, m_seq);
    lat_prev = l;
    m_seq    = m_seq + 8'd1;
    exp_start++;
    if (d < 0) begin
      wait_until(s + 7);
      chk("tx_err_early", tx_err, 0);
      wait_until(s + 8);
      chk("tx_err_pulse", tx_err, 1);
      exp_err++;
      m_seq = m_seq + 8'd1;
      wait_until(s + 9);
      chk("tx_err_width", tx_err, 0);
    end else begin
      wait_until(s + d);
      tx_busy = 1'b1;
      wait_until(s + d + len);
      chk("frame_hold", tx_frame, exp);
      tx_busy = 1'b0;
    end
    wait_until(cyc + 2);
    chk("start_count", n_start, exp_start);
    chk("overrun_count", n_ovr, exp_ovr);
    chk("tx_err_count", n_err, exp_err);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; payload_in = '0; payload_valid = 1'b0;
    rx_frame_done = 1'b0; check_sum_error = 1'b0; comNoResponse = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame", tx_frame, 0);
    chk("rst_start", tx_frame_start, 0);
    chk("rst_seq", seq, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tx_err", tx_err, 0);
    reset = 1'b0;
    enable = 1'b1;

    // First frame: empty payload, no events.
    do_frame(99, 2, 10);
    fr = tx_frame;
    chk("a_sof_l", fr[7:0], 8'hEB);
    chk("a_sof_h", fr[15:8], 8'h90);
    chk("a_seq", fr[23:16], 8'h00);
    chk("a_stat", fr[31:24], 8'h00);
    chk("a_payload", fr[247:32], 0);
    chk("a_cs", fr[255:248], 8'h7B);

    // Three good frames and one checksum error before the latch.
    drive(160, 1, 0, 0, 0, '0);
    drive(165, 1, 0, 0, 0, '0);
    drive(170, 1, 0, 0, 0, '0);
    drive(175, 0, 1, 0, 0, '0);
    do_frame(199, 3, 12);
    fr = tx_frame;
    chk("b_seq", fr[23:16], 8'h01);
    chk("b_stat", fr[31:24], 8'h33);

    // Payload load in the LATCH cycle goes to the following frame.
    p = rand_pay();
    p[7:0] = 8'hA5;
    drive(300, 0, 0, 0, 1, p);
    do_frame(299, 1, 5);
    fr = tx_frame;
    chk("c_stat", fr[31:24], 8'h00);
    chk("c_byte4", fr[39:32], 8'h00);
    rand_events(404, 1'b0);
    do_frame(399, 4, 8);
    fr = tx_frame;
    chk("d_byte4", fr[39:32], 8'hA5);

    // Transmitter stays busy across three ticks.
    rand_events(504, 1'b1);
    exp_ovr = exp_ovr + 3;
    do_frame(499, 1, 277);

    // Transmitter never answers; the next frame skips a sequence number.
    rand_events(904, 1'b1);
    s_fail = m_seq;
    do_frame(899, -1, 0);
    rand_events(1004, 1'b1);
    do_frame(999, 2, 6);
    fr = tx_frame;
    tmp8 = s_fail + 8'd2;
    chk("g_seq_gap", fr[23:16], tmp8);

    // Enable dropped mid-frame: this frame completes, the next tick is ignored.
    rand_events(1104, 1'b1);
    wait_until(1120);
    enable = 1'b0;
    do_frame(1099, 3, 9);
    rand_events(1240, 1'b1);
    chk("no_frame_disabled", n_start, exp_start);
    wait_until(1250);
    enable = 1'b1;
    rand_events(1304, 1'b1);
    do_frame(1299, 2, 7);

    // Randomized frames.
    for (int m = 0; m < 4; m++) begin
      rand_events(1404 + 100*m, 1'b1);
      do_frame(1399 + 100*m, int'($urandom_range(1, 6)), int'($urandom_range(3, 20)));
    end

    // Reset in the middle of SUM.
    rand_events(1790, 1'b1);
    wait_until(1805);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_frame", tx_frame, 0);
    chk("mid_rst_start", tx_frame_start, 0);
    chk("mid_rst_seq", seq, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_tx_err", tx_err, 0);
    evq.delete();
    lat_prev = 0;
    m_seq = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    rand_events(104, 1'b1);
    do_frame(99, 2, 10);
    fr = tx_frame;
    chk("post_rst_seq", fr[23:16], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
